// File: rtl/spram_arbiter_if.sv
// ============================================================================
// Module      : spram_arbiter_if
// Description : Request/response handshakes and SPRAM control pins shared by
//               the spram_arbiter and its surroundings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              init_done;

    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic [ADDR_W-1:0] ram_adr;
    logic [DATA_W-1:0] ram_d;
    logic              ram_enb;
    logic              ram_web;
    logic              ram_oeb;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        output init_done,
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output ram_adr, ram_d, ram_enb, ram_web, ram_oeb,
        input  ram_q
    );

    modport master (
        input  init_done,
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  ram_adr, ram_d, ram_enb, ram_web, ram_oeb,
        output ram_q
    );
endinterface

`default_nettype wire

// File: rtl/spram_arbiter.sv
// ============================================================================
// Module      : spram_arbiter
// Description : Round-robin two-requester sequencer for one SPRAM256X8 macro,
//               with a power-up holdoff before the first access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spram_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int STARTUP_CYCLES = 10
) (
    input  wire logic       clk,
    input  wire logic       reset,
    spram_arbiter_if.slave  bus
);

    localparam int c_CNT_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STARTUP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STARTUP   = 2'd0,
        ST_IDLE      = 2'd1,
        ST_ACCESS    = 2'd2,
        ST_READ_WAIT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_init_done;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic                r_id;
    logic                r_last_grant;
    logic                r_rsp0_valid;
    logic                r_rsp1_valid;
    logic [DATA_W-1:0]   r_rsp0_rdata;
    logic [DATA_W-1:0]   r_rsp1_rdata;

    logic                w_pick0;
    logic                w_pick1;
    logic                w_ready0;
    logic                w_ready1;
    logic                w_hs0;
    logic                w_hs1;
    logic                w_enb;
    logic                w_web;
    logic                w_oeb;

    // On a tie the requester that did not win last time goes first.
    assign w_pick1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    assign w_pick0 = bus.req0_valid && !w_pick1;

    assign w_hs0 = w_ready0 && bus.req0_valid;
    assign w_hs1 = w_ready1 && bus.req1_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_STARTUP;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        w_enb    = 1'b1;
        w_web    = 1'b1;
        w_oeb    = 1'b1;
        case (r_state)
            ST_STARTUP: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_ready0 = w_pick0;
                w_ready1 = w_pick1;
                if (w_pick0 || w_pick1) begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_enb = 1'b0;
                if (r_we) begin
                    w_web  = 1'b0;
                    w_next = ST_IDLE;
                end else begin
                    w_oeb  = 1'b0;
                    w_next = ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                w_enb  = 1'b0;
                w_oeb  = 1'b0;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_STARTUP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == ST_STARTUP) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (r_cnt == c_CNT_LAST) begin
                r_init_done <= 1'b1;
            end
        end
    end

    // The latched request doubles as the held RAM address/data between accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_hs0 || w_hs1) begin
            r_addr       <= w_hs1 ? bus.req1_addr  : bus.req0_addr;
            r_wdata      <= w_hs1 ? bus.req1_wdata : bus.req0_wdata;
            r_we         <= w_hs1 ? bus.req1_we    : bus.req0_we;
            r_id         <= w_hs1;
            r_last_grant <= w_hs1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            r_rsp0_valid <= (r_state == ST_READ_WAIT) && !r_id;
            r_rsp1_valid <= (r_state == ST_READ_WAIT) &&  r_id;
            if (r_state == ST_READ_WAIT) begin
                if (r_id) begin
                    r_rsp1_rdata <= bus.ram_q;
                end else begin
                    r_rsp0_rdata <= bus.ram_q;
                end
            end
        end
    end

    assign bus.init_done  = r_init_done;
    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp0_rdata = r_rsp0_rdata;
    assign bus.rsp1_rdata = r_rsp1_rdata;
    assign bus.ram_adr    = r_addr;
    assign bus.ram_d      = r_wdata;
    assign bus.ram_enb    = w_enb;
    assign bus.ram_web    = w_web;
    assign bus.ram_oeb    = w_oeb;

endmodule

`default_nettype wire
